sccb_init_seq: RTL and testbench
================================

Name: sccb_init_seq

Overview:
- Parametrised successor to the camera register-init sequencer.
- Walks an external register table: drives the table index, decodes each 16-bit entry ({reg_addr, reg_data}) and issues SCCB writes through the existing req/busy master handshake.
- Adds configurable table depth, in-table delay and end-marker entries, NACK retry with an error exit, an accept timeout, and restart from DONE/ERROR.
- Sits between the top-level init controller and the SCCB master.

Parameters:
- LUT_DEPTH, 165: number of table entries. Index LUT_DEPTH-1 is the last entry executed.
- IDX_W, 8: width of LUT_INDEX. Must satisfy 2**IDX_W >= LUT_DEPTH.
- DELAY_UNIT, 50000: S_CLK cycles per delay tick (1 ms at 50 MHz).
- MAX_RETRY, 3: re-issues allowed per entry after a NACK.
- ACCEPT_TO, 1023: S_CLK cycles to wait for SCCB_busy to rise before timing out.

Ports:
- S_CLK  in  1  system clock
- RST  in  1  reset
- start_init  in  1  level; starts the sequence from IDLE, restarts it from DONE/ERROR
- init_done  out  1  high while in DONE
- init_err  out  1  high while in ERROR
- err_index  out  IDX_W  index of the failing entry; valid while init_err is high
- SCCB_req  out  1  transaction request to the SCCB master
- SCCB_busy  in  1  SCCB master busy
- SCCB_nack  in  1  slave NACK; the master holds it valid on the cycle busy falls
- SCCB_addr  out  8  register address, registered
- SCCB_data  out  8  register data, registered
- LUT_INDEX  out  IDX_W  table index
- LUT_DATA  in  16  table entry; synchronous ROM, valid one cycle after LUT_INDEX changes

Interface: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset values: all outputs 0; state IDLE; retry, delay and timeout counters 0.
- States: IDLE, FETCH, DECODE, ISSUE, WAIT_DONE, DELAY, DONE, ERROR.
- IDLE: on start_init=1 -> FETCH with LUT_INDEX=0.
- FETCH: one wait cycle for ROM latency -> DECODE.
- DECODE, by LUT_DATA:
  - 16'hFFFF -> DONE (early end marker).
  - High byte 8'hFE -> DELAY, loading a tick count of LUT_DATA[7:0]. A count of 0 goes straight to NEXT.
  - Anything else -> latch SCCB_addr=LUT_DATA[15:8] and SCCB_data=LUT_DATA[7:0], then -> ISSUE.
- ISSUE:
  - SCCB_req=1 and the timeout counter increments.
  - On the first cycle with SCCB_busy=1: SCCB_req drops to 0 next cycle -> WAIT_DONE.
  - If the counter reaches ACCEPT_TO with busy still 0 -> ERROR.
  - If busy is already 1 on entry to ISSUE, it counts as an accept.
- WAIT_DONE: on the first cycle with SCCB_busy=0, sample SCCB_nack.
  - nack=0 -> NEXT.
  - nack=1 and retry < MAX_RETRY -> retry+1, back to ISSUE with the same addr/data.
  - nack=1 and retry == MAX_RETRY -> ERROR.
- DELAY: counts ticks × DELAY_UNIT cycles, then NEXT.
- NEXT (an action, not a state):
  - Clear retry.
  - If LUT_INDEX == LUT_DEPTH-1 -> DONE.
  - Else LUT_INDEX+1 -> FETCH.
  - LUT_INDEX never wraps.
- DONE: init_done=1 and SCCB_req=0. On start_init=1 (including start_init held high, which is treated as a level) -> clear init_done, LUT_INDEX=0 -> FETCH.
- ERROR:
  - init_err=1; err_index=LUT_INDEX captured on entry; SCCB_req=0.
  - start_init=1 -> clear init_err/err_index, LUT_INDEX=0 -> FETCH.
- Invariants:
  - SCCB_req is only ever high in ISSUE.
  - init_done and init_err are mutually exclusive.
- Reset mid-operation: immediate return to reset values, even with a transaction in flight. The SCCB master handles its own abort.
- All arithmetic is unsigned.
  - Tick counter is 8 bit.
  - Cycle counter is clog2(DELAY_UNIT) bits.
  - Timeout counter is clog2(ACCEPT_TO+1) bits.
  - Retry counter is clog2(MAX_RETRY+1) bits.
- Latency for a normal write entry: FETCH(1) + DECODE(1) + ISSUE(≥1) + master time + 1 cycle to NEXT.

Decomposition:
- Shared package sccb_pkg:
  - State enum.
  - Markers END_MARK=16'hFFFF and DLY_TAG=8'hFE.
  - SCCB write-address constants (8'h42 for OV7670).
- Sub-module sccb_delay_timer: tick × DELAY_UNIT down-counter with load/done. Also reusable for power-up delays.

Test Plan:
- LUT_DEPTH=4, entries {12'80, 11'01, 3A'04, 40'D0}, master model acks with busy high for 20 cycles -> four requests with addr/data matching in order, init_done=1, LUT_INDEX=3, SCCB_req=0.
- Entry 1 = FE'02, DELAY_UNIT=10 -> exactly 20 cycles (±2 for state overhead) with no SCCB_req between entry 0 completing and entry 2 being issued.
- Entry 2 = FFFF with LUT_DEPTH=8 -> init_done after entry 1, entries 3..7 never requested.
- NACK on entry 1 twice, then ack, MAX_RETRY=3 -> three requests for 11'01, sequence completes, init_done=1.
- NACK always on entry 2 -> 4 requests total for that entry, init_err=1, err_index=2. Then pulsing start_init -> restart from index 0, init_err=0.
- SCCB_busy held 0 with ACCEPT_TO=15 -> ERROR after 15 ISSUE cycles. Separately, asserting RST mid-WAIT_DONE -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB register-init sequencer: state codes,
// table markers and camera address constants.
package sccb_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE      = 3'd0;
  localparam state_t S_FETCH     = 3'd1;
  localparam state_t S_DECODE    = 3'd2;
  localparam state_t S_ISSUE     = 3'd3;
  localparam state_t S_WAIT_DONE = 3'd4;
  localparam state_t S_DELAY     = 3'd5;
  localparam state_t S_DONE      = 3'd6;
  localparam state_t S_ERROR     = 3'd7;

  // Table entries: {reg_addr, reg_data}; FFFF ends early, FE_xx waits xx ticks.
  localparam logic [15:0] END_MARK = 16'hFFFF;
  localparam logic [7:0]  DLY_TAG  = 8'hFE;

  localparam logic [7:0] OV7670_WADDR = 8'h42;
  localparam logic [7:0] OV7670_RADDR = 8'h43;

  function automatic logic is_delay_entry(input logic [15:0] entry);
    return entry[15:8] == DLY_TAG;
  endfunction

endpackage

// File: rtl/sccb_delay_timer.sv
// Down-counter that waits ticks x DELAY_UNIT clock cycles after a load and
// flags the final cycle with done. A zero tick count never starts.
module sccb_delay_timer #(
  parameter int DELAY_UNIT = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] ticks,
  output logic       done
);

  localparam int CYC_W = (DELAY_UNIT > 1) ? $clog2(DELAY_UNIT) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(DELAY_UNIT - 1);

  logic             active_q, active_d;
  logic [7:0]       tick_q, tick_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;

  always_comb begin
    active_d = active_q;
    tick_d   = tick_q;
    cyc_d    = cyc_q;
    done     = 1'b0;
    if (load) begin
      active_d = (ticks != 8'd0);
      tick_d   = ticks;
      cyc_d    = CYC_LAST;
    end else if (active_q) begin
      if (cyc_q == '0) begin
        if (tick_q == 8'd1) begin
          done     = 1'b1;
          active_d = 1'b0;
          tick_d   = 8'd0;
        end else begin
          tick_d = tick_q - 8'd1;
          cyc_d  = CYC_LAST;
        end
      end else begin
        cyc_d = cyc_q - CYC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      tick_q   <= 8'd0;
      cyc_q    <= '0;
    end else begin
      active_q <= active_d;
      tick_q   <= tick_d;
      cyc_q    <= cyc_d;
    end
  end

endmodule

// File: rtl/sccb_init_seq.sv
// Camera register-init sequencer: walks an external synchronous ROM and
// issues SCCB writes, delays and end markers, with NACK retry and accept timeout.
module sccb_init_seq
  import sccb_pkg::*;
#(
  parameter int LUT_DEPTH  = 165,
  parameter int IDX_W      = 8,
  parameter int DELAY_UNIT = 50000,
  parameter int MAX_RETRY  = 3,
  parameter int ACCEPT_TO  = 1023
) (
  input  logic             S_CLK,
  input  logic             RST,
  input  logic             start_init,
  output logic             init_done,
  output logic             init_err,
  output logic [IDX_W-1:0] err_index,
  output logic             SCCB_req,
  input  logic             SCCB_busy,
  input  logic             SCCB_nack,
  output logic [7:0]       SCCB_addr,
  output logic [7:0]       SCCB_data,
  output logic [IDX_W-1:0] LUT_INDEX,
  input  logic [15:0]      LUT_DATA
);

  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TO_W  = (ACCEPT_TO > 1) ? $clog2(ACCEPT_TO + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LUT_DEPTH - 1);
  localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRY);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(ACCEPT_TO - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] err_idx_q, err_idx_d;
  logic [7:0]       addr_q, addr_d, data_q, data_d;
  logic             req_q, req_d, done_q, done_d, err_q, err_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             dly_load, dly_done, do_next, go_err;

  sccb_delay_timer #(.DELAY_UNIT(DELAY_UNIT)) u_delay (
    .clk   (S_CLK),
    .rst   (RST),
    .load  (dly_load),
    .ticks (LUT_DATA[7:0]),
    .done  (dly_done)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_idx_d = err_idx_q;
    addr_d    = addr_q;
    data_d    = data_q;
    req_d     = req_q;
    done_d    = done_q;
    err_d     = err_q;
    retry_d   = retry_q;
    to_d      = to_q;
    dly_load  = 1'b0;
    do_next   = 1'b0;
    go_err    = 1'b0;
    case (state_q)
      S_IDLE: if (start_init) begin
        idx_d   = '0;
        retry_d = '0;
        state_d = S_FETCH;
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (LUT_DATA == END_MARK) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (is_delay_entry(LUT_DATA)) begin
          if (LUT_DATA[7:0] == 8'd0) begin
            do_next = 1'b1;
          end else begin
            dly_load = 1'b1;
            state_d  = S_DELAY;
          end
        end else begin
          addr_d  = LUT_DATA[15:8];
          data_d  = LUT_DATA[7:0];
          req_d   = 1'b1;
          to_d    = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (SCCB_busy) begin
          req_d   = 1'b0;
          to_d    = '0;
          state_d = S_WAIT_DONE;
        end else begin
          to_d = to_q + TO_W'(1);
          if (to_q == TO_LAST) go_err = 1'b1;
        end
      end
      // nack is only meaningful on the cycle busy falls
      S_WAIT_DONE: if (!SCCB_busy) begin
        if (!SCCB_nack) begin
          do_next = 1'b1;
        end else if (retry_q < RTY_MAX) begin
          retry_d = retry_q + RTY_W'(1);
          req_d   = 1'b1;
          to_d    = '0;
          state_d = S_ISSUE;
        end else begin
          go_err = 1'b1;
        end
      end
      S_DELAY: if (dly_done) do_next = 1'b1;
      S_DONE: if (start_init) begin
        done_d  = 1'b0;
        idx_d   = '0;
        retry_d = '0;
        state_d = S_FETCH;
      end
      S_ERROR: if (start_init) begin
        err_d     = 1'b0;
        err_idx_d = '0;
        idx_d     = '0;
        retry_d   = '0;
        state_d   = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
    if (do_next) begin
      retry_d = '0;
      if (idx_q == LAST_IDX) begin
        done_d  = 1'b1;
        state_d = S_DONE;
      end else begin
        idx_d   = idx_q + IDX_W'(1);
        state_d = S_FETCH;
      end
    end
    if (go_err) begin
      req_d     = 1'b0;
      err_d     = 1'b1;
      err_idx_d = idx_q;
      state_d   = S_ERROR;
    end
  end

  always_ff @(posedge S_CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      err_idx_q <= '0;
      addr_q    <= 8'd0;
      data_q    <= 8'd0;
      req_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      retry_q   <= '0;
      to_q      <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      err_idx_q <= err_idx_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      req_q     <= req_d;
      done_q    <= done_d;
      err_q     <= err_d;
      retry_q   <= retry_d;
      to_q      <= to_d;
    end
  end

  assign init_done = done_q;
  assign init_err  = err_q;
  assign err_index = err_idx_q;
  assign SCCB_req  = req_q;
  assign SCCB_addr = addr_q;
  assign SCCB_data = data_q;
  assign LUT_INDEX = idx_q;

endmodule

// File: tb/tb_sccb_init_seq.sv
// Bench for sccb_init_seq: ROM and SCCB master models, scoreboard of expected
// {addr,data} writes checked by a request monitor, plus end-state checks.
module tb_sccb_init_seq;

  localparam int BUSY_CYC = 20;

  logic        S_CLK, RST, start_init;
  logic        init_done, init_err, SCCB_req, SCCB_busy, SCCB_nack;
  logic [7:0]  err_index, SCCB_addr, SCCB_data, LUT_INDEX;
  logic [15:0] LUT_DATA;

  sccb_init_seq #(
    .LUT_DEPTH(8), .IDX_W(8), .DELAY_UNIT(10), .MAX_RETRY(3), .ACCEPT_TO(15)
  ) dut (
    .S_CLK(S_CLK), .RST(RST), .start_init(start_init),
    .init_done(init_done), .init_err(init_err), .err_index(err_index),
    .SCCB_req(SCCB_req), .SCCB_busy(SCCB_busy), .SCCB_nack(SCCB_nack),
    .SCCB_addr(SCCB_addr), .SCCB_data(SCCB_data),
    .LUT_INDEX(LUT_INDEX), .LUT_DATA(LUT_DATA)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [15:0] rom [0:7];
  logic [15:0] sb [$];
  int          req_t [$];
  int          drop_t [$];
  logic        mute = 1'b0;
  logic [7:0]  nack_addr = 8'h00;
  int          nack_left = 0;

  initial begin
    S_CLK = 1'b0;
    forever #5 S_CLK = ~S_CLK;
  end

  always @(posedge S_CLK) cyc <= cyc + 1;
  always @(posedge S_CLK) LUT_DATA <= rom[LUT_INDEX[2:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // SCCB master model: accepts a request, stays busy, then reports nack
  initial begin
    SCCB_busy = 1'b0;
    SCCB_nack = 1'b0;
    forever begin
      @(negedge S_CLK);
      SCCB_nack = 1'b0;
      if (!mute && SCCB_req && !SCCB_busy) begin
        SCCB_busy = 1'b1;
        repeat (BUSY_CYC - 1) @(negedge S_CLK);
        SCCB_busy = 1'b0;
        if (SCCB_addr == nack_addr && nack_left > 0) begin
          SCCB_nack = 1'b1;
          nack_left--;
        end
        drop_t.push_back(cyc);
      end
    end
  end

  // Monitor: every rising SCCB_req must match the next expected write
  initial begin
    logic prev_req;
    logic [15:0] exp;
    prev_req = 1'b0;
    forever begin
      @(negedge S_CLK);
      if (SCCB_req && !prev_req) begin
        req_t.push_back(cyc);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_req: got %02h%02h required none", SCCB_addr, SCCB_data);
        end else begin
          exp = sb.pop_front();
          chk("req_addr_data", {16'h0, SCCB_addr, SCCB_data}, {16'h0, exp});
        end
      end
      prev_req = SCCB_req;
    end
  end

  task automatic pulse_start();
    @(negedge S_CLK);
    start_init = 1'b1;
    @(negedge S_CLK);
    start_init = 1'b0;
  endtask

  task automatic wait_end(output int t_end);
    int n;
    n = 0;
    t_end = 0;
    while (!(init_done || init_err) && n < 3000) begin
      @(negedge S_CLK);
      n++;
    end
    if (!(init_done || init_err)) begin
      total++;
      bad++;
      $display("FAIL wait_end: got no done/err required done or err within 3000 cycles");
    end
    t_end = cyc;
  endtask

  task automatic load_rom(input logic [15:0] e0, e1, e2, e3, e4, e5, e6, e7);
    rom[0] = e0; rom[1] = e1; rom[2] = e2; rom[3] = e3;
    rom[4] = e4; rom[5] = e5; rom[6] = e6; rom[7] = e7;
  endtask

  initial begin
    int t_end;
    int n;
    RST = 1'b1;
    start_init = 1'b0;
    load_rom(16'h1280, 16'h1101, 16'h3A04, 16'h40D0, 16'h8C00, 16'h3E1A, 16'h703A, 16'h7135);
    repeat (3) @(negedge S_CLK);
    RST = 1'b0;
    @(negedge S_CLK);
    chk("rst_req", SCCB_req, 0);
    chk("rst_done", init_done, 0);
    chk("rst_err", init_err, 0);
    chk("rst_err_index", err_index, 0);
    chk("rst_addr", SCCB_addr, 0);
    chk("rst_data", SCCB_data, 0);
    chk("rst_index", LUT_INDEX, 0);

    // full table of eight writes
    for (int i = 0; i < 8; i++) sb.push_back(rom[i]);
    pulse_start();
    wait_end(t_end);
    repeat (2) @(negedge S_CLK);
    chk("full_done", init_done, 1);
    chk("full_err", init_err, 0);
    chk("full_index", LUT_INDEX, 7);
    chk("full_req", SCCB_req, 0);
    chk("full_sb_empty", sb.size(), 0);

    // delay entry then early end marker
    load_rom(16'h1280, 16'hFE02, 16'h1101, 16'hFFFF, 16'h5555, 16'h5656, 16'h5757, 16'h5858);
    sb.push_back(16'h1280);
    sb.push_back(16'h1101);
    req_t.delete();
    drop_t.delete();
    pulse_start();
    wait_end(t_end);
    repeat (30) @(negedge S_CLK);
    chk("end_done", init_done, 1);
    chk("end_index", LUT_INDEX, 3);
    chk("end_sb_empty", sb.size(), 0);
    chk("delay_req_count", req_t.size(), 2);
    if (req_t.size() >= 2 && drop_t.size() >= 1)
      chk("delay_gap", req_t[1] - drop_t[0], 25);

    // two nacks on 0x11 then ack; zero-length delay entry
    load_rom(16'h1280, 16'h1101, 16'hFE00, 16'h3A04, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000);
    sb.push_back(16'h1280);
    repeat (3) sb.push_back(16'h1101);
    sb.push_back(16'h3A04);
    nack_addr = 8'h11;
    nack_left = 2;
    pulse_start();
    wait_end(t_end);
    repeat (2) @(negedge S_CLK);
    chk("retry_done", init_done, 1);
    chk("retry_err", init_err, 0);
    chk("retry_index", LUT_INDEX, 4);
    chk("retry_sb_empty", sb.size(), 0);

    // persistent nack on entry 2 exhausts retries
    load_rom(16'h1280, 16'h1101, 16'h3A04, 16'h40D0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000);
    sb.push_back(16'h1280);
    sb.push_back(16'h1101);
    repeat (4) sb.push_back(16'h3A04);
    nack_addr = 8'h3A;
    nack_left = 1000;
    pulse_start();
    wait_end(t_end);
    repeat (2) @(negedge S_CLK);
    chk("nack_err", init_err, 1);
    chk("nack_done", init_done, 0);
    chk("nack_err_index", err_index, 2);
    chk("nack_req", SCCB_req, 0);
    chk("nack_sb_empty", sb.size(), 0);

    nack_left = 0;
    sb.push_back(16'h1280);
    sb.push_back(16'h1101);
    sb.push_back(16'h3A04);
    sb.push_back(16'h40D0);
    pulse_start();
    chk("restart_err", init_err, 0);
    chk("restart_err_index", err_index, 0);
    wait_end(t_end);
    repeat (2) @(negedge S_CLK);
    chk("restart_done", init_done, 1);
    chk("restart_index", LUT_INDEX, 4);
    chk("restart_sb_empty", sb.size(), 0);

    // master never accepts: accept timeout
    mute = 1'b1;
    req_t.delete();
    sb.push_back(16'h1280);
    pulse_start();
    wait_end(t_end);
    chk("to_err", init_err, 1);
    chk("to_err_index", err_index, 0);
    chk("to_req", SCCB_req, 0);
    if (req_t.size() >= 1)
      chk("to_cycles", t_end - req_t[0], 15);
    mute = 1'b0;

    // asynchronous reset while a write is in flight
    sb.push_back(16'h1280);
    pulse_start();
    n = 0;
    while (!SCCB_busy && n < 100) begin
      @(negedge S_CLK);
      n++;
    end
    chk("arst_busy_seen", SCCB_busy, 1);
    repeat (3) @(negedge S_CLK);
    #2 RST = 1'b1;
    #1;
    chk("arst_req", SCCB_req, 0);
    chk("arst_addr", SCCB_addr, 0);
    chk("arst_data", SCCB_data, 0);
    chk("arst_index", LUT_INDEX, 0);
    chk("arst_done", init_done, 0);
    chk("arst_err", init_err, 0);
    chk("arst_err_index", err_index, 0);
    n = 0;
    while (SCCB_busy && n < 100) begin
      @(negedge S_CLK);
      n++;
    end
    sb.delete();
    @(negedge S_CLK);
    RST = 1'b0;
    repeat (5) @(negedge S_CLK);
    chk("post_rst_req", SCCB_req, 0);
    chk("post_rst_done", init_done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
